// File: rtl/float_to_bi.sv
// float_to_bi: decodes an 8-bit compressed float {sign, E[2:0], S[3:0]} into a
// 12-bit two's-complement linear value, magnitude = S << E.
// The magnitude is built by a serial shifter, one bit position per clock.
// Valid/ready handshakes are used on both the input and the output side.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  ft holds a float to decode
//   in_ready  block can accept a float (state is IDLE)
//   ft        float input {sign, E, S}
//   out_valid bi holds a decoded result
//   out_ready consumer accepts bi
//   bi        two's-complement result
//   busy      high in SHIFT or DONE
//
// Only EXP_W = 3 and SIG_W = 4 are supported.
// OUT_W must be at least SIG_W + 2**EXP_W.
module float_to_bi #(
    parameter int unsigned EXP_W = 3,
    parameter int unsigned SIG_W = 4,
    parameter int unsigned OUT_W = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+SIG_W:0]   ft,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       bi,
    output logic                   busy
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    localparam logic [OUT_W-1:0] MagOne = OUT_W'(1);
    localparam logic [EXP_W-1:0] CntOne = EXP_W'(1);

    logic [1:0]       state_q, state_d;
    logic [OUT_W-1:0] mag_q, mag_d;
    logic [EXP_W-1:0] cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic [OUT_W-1:0] bi_q, bi_d;
    logic             out_valid_q, out_valid_d;

    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        bi_d        = bi_q;
        out_valid_d = out_valid_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sign_d  = ft[EXP_W+SIG_W];
                    cnt_d   = ft[SIG_W +: EXP_W];
                    mag_d   = {{(OUT_W-SIG_W){1'b0}}, ft[SIG_W-1:0]};
                    state_d = StShift;
                end
            end
            StShift: begin
                if (cnt_q != '0) begin
                    mag_d = mag_q << 1;
                    cnt_d = cnt_q - CntOne;
                end else begin
                    // A zero magnitude stays zero regardless of sign: no negative zero.
                    bi_d        = (sign_q && (mag_q != '0)) ? (~mag_q + MagOne) : mag_q;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                // bi is left holding the last result after the handshake.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d     = StIdle;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mag_q       <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            bi_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            bi_q        <= bi_d;
            out_valid_q <= out_valid_d;
        end
    end

    // All outputs come from registers or from state decode only.
    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = out_valid_q;
    assign bi        = bi_q;

endmodule

// File: doc/float_to_bi.md
Name: float_to_bi

Overview:
- Decodes the team's 8-bit compressed float into a 12-bit two's-complement linear value.
- Float format: ft[7] = sign, ft[6:4] = exponent E (0..7), ft[3:0] = significand S (no hidden bit). Magnitude = S << E.
- This block is the inverse path of the existing linear-to-float encoder. It runs as a multi-cycle serial shifter with valid/ready handshakes on both input and output.

Parameters:
- EXP_W, 3, exponent field width. This block supports only 3.
- SIG_W, 4, significand field width. This block supports only 4.
- OUT_W, 12, output word width. Must be at least SIG_W + 2^EXP_W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  ft holds a float to decode
- in_ready  output  1  block can accept a float
- ft  input  8  float input {sign, E[2:0], S[3:0]}
- out_valid  output  1  bi holds a decoded result
- out_ready  input  1  consumer accepts bi
- bi  output  12  two's-complement result
- busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; in_ready = 1; out_valid = 0; bi = 12'h000; busy = 0.
  - Internal mag, cnt and sign registers are cleared.
  - A reset in any state aborts the operation in progress. No partial result is ever presented.
- States: IDLE, SHIFT, DONE. State encoding is free; state must be registered.
- in_ready = (state == IDLE). It is a pure function of state, with no combinational path from out_ready.
- busy = (state != IDLE).
- IDLE:
  - On a clock edge with in_valid && in_ready: capture sign = ft[7], cnt = ft[6:4], mag = zero-extended ft[3:0] (12 bits), then go to SHIFT.
  - Otherwise stay in IDLE. ft is sampled only at the accepting edge; later changes on ft are ignored.
- SHIFT:
  - Each edge with cnt != 0: mag <= mag << 1; cnt <= cnt - 1.
  - Edge with cnt == 0: bi <= (sign && mag != 0) ? (~mag + 1) : mag; out_valid <= 1; go to DONE.
- DONE:
  - bi and out_valid are held stable while out_ready = 0.
  - On an edge with out_ready = 1: out_valid <= 0, go to IDLE. bi keeps its last value until the next result.
- Latency:
  - out_valid rises E+1 edges after the accepting edge: 1 cycle for E = 0, 8 cycles for E = 7.
  - Minimum issue interval is E+3 cycles, because DONE and IDLE each take at least one cycle. There is no bypass from DONE directly to SHIFT.
- Arithmetic:
  - Maximum magnitude is 15 << 7 = 1920 (0x780). It always fits in 11 bits, so no overflow or saturation is possible.
  - Negative results are exact two's complement of the magnitude.
- Zero handling:
  - S = 0 gives 0x000 for any E and either sign.
  - A float with sign = 1 and magnitude 0 outputs 0x000, never a negative zero.
- in_valid while busy: ignored. in_ready = 0 is the backpressure signal, and the upstream producer must hold the float.
- out_ready while not in DONE: ignored.
- out_valid, bi, in_ready and busy are driven from registers or state decode only, with no combinational input-to-output paths.
- Fully synchronous apart from the asynchronous reset.

Test Plan:
- Reset, then ft = 0x00, in_valid for 1 cycle, out_ready = 1 -> out_valid rises 1 edge after accept, bi = 0x000, state returns to IDLE next edge.
- ft = 0x4F (E = 4, S = 15) -> out_valid 5 edges after accept, bi = 0x0F0 (240). ft = 0x3A -> bi = 0x050 after 4 edges.
- ft = 0xFF -> bi = 0x880 (-1920) after 8 edges. ft = 0xF8 -> bi = 0xC00 (-1024). ft = 0x91 -> bi = 0xFFE (-2).
- ft = 0x80 and ft = 0xF0 -> bi = 0x000 in both cases; check for no 0xFFF or other negative-zero artefact.
- Backpressure: hold out_ready = 0 for 3 cycles after out_valid rises with ft = 0x2C -> bi stays 0x030, out_valid stays 1, in_ready stays 0. A different ft with in_valid = 1 during this window is not captured. Raising out_ready -> IDLE on the next edge.
- Drop rst_n mid-SHIFT (ft = 0x7F, 3 cycles after accept) -> out_valid = 0, bi = 0x000, in_ready = 1 immediately, with no clock edge required. After release, ft = 0x15 -> bi = 0x00A.
